// File: rtl/ps2_pkg.sv
// Shared types and default parameters for the multi-channel PS/2 receiver.
package ps2_pkg;

  localparam int PS2_BYTE_W = 8;

  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_FIFO_DEPTH  = 8;
  localparam int DEF_FILTER_LEN  = 4;
  localparam int DEF_TIMEOUT_CYC = 4096;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

endpackage

// File: rtl/ps2_rx_chan.sv
// One PS/2 receive channel: synchroniser, clock filter, frame FSM, byte FIFO.
// Define PS2_RX_TIMEOUT_EN to build the in-frame timeout counter.
module ps2_rx_chan
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  output logic [PS2_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  perr,
  output logic                  ferr,
  output logic                  ovf
);

  localparam int FILT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  logic [1:0] clk_sync, data_sync;

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  logic              filt_clk;
  logic [FILT_W-1:0] filt_cnt;
  logic              filt_take;
  logic              sample;
  logic              bit_in;

  assign filt_take = (clk_sync[1] != filt_clk) && (filt_cnt == FILT_W'(FILTER_LEN - 1));
  assign sample    = filt_take && filt_clk;
  assign bit_in    = data_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync[1] == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_take) begin
      filt_clk <= clk_sync[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FILT_W'(1);
    end
  end

  frame_state_t          state;
  logic [2:0]            bit_cnt;
  logic [PS2_BYTE_W-1:0] shreg;
  logic                  par_acc;
  logic                  timeout_hit;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] to_cnt;

  assign timeout_hit = (state != ST_IDLE) && !sample && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset || sample || timeout_hit || state == ST_IDLE) to_cnt <= '0;
    else                                                    to_cnt <= to_cnt + TO_W'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_acc <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      perr <= 1'b0;
      ferr <= 1'b0;
      if (timeout_hit) begin
        state <= ST_IDLE;
        ferr  <= 1'b1;
      end else if (sample) begin
        case (state)
          ST_IDLE: if (!bit_in) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
            par_acc <= 1'b0;
          end
          ST_DATA: begin
            shreg   <= {bit_in, shreg[PS2_BYTE_W-1:1]};
            par_acc <= par_acc ^ bit_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_acc <= par_acc ^ bit_in;
            state   <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if (bit_in) perr <= ~par_acc;
            else        ferr <= 1'b1;
          end
        endcase
      end
    end
  end

  // Good frame: stop bit high and odd overall parity across data plus parity bit.
  logic push_req, push_ok, pop, full;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        level;
  logic [PS2_BYTE_W-1:0] mem [FIFO_DEPTH];

  assign push_req = sample && (state == ST_STOP) && bit_in && par_acc && !timeout_hit;
  assign full     = (level == (PTR_W + 1)'(FIFO_DEPTH));
  assign pop      = rx_valid && rx_ready;
  assign push_ok  = push_req && (!full || pop);
  assign rx_valid = (level != '0);
  assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

  // NOTE: the storage array has no reset; validity is tracked by level, and rx_data is gated when empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      ovf <= push_req && full && !pop;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      level <= level + (PTR_W + 1)'(1);
      else if (!push_ok && pop) level <= level - (PTR_W + 1)'(1);
    end
  end

endmodule

// File: rtl/ps2_rx_multi.sv
// Multi-channel PS/2 device-to-host byte receiver; one independent ps2_rx_chan per port.
// Define PS2_RX_TIMEOUT_EN to enable per-channel frame timeout recovery.
module ps2_rx_multi
  import ps2_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ps2_clk,
  input  logic [NUM_CH-1:0]            ps2_data,
  output logic [PS2_BYTE_W*NUM_CH-1:0] rx_data,
  output logic [NUM_CH-1:0]            rx_valid,
  input  logic [NUM_CH-1:0]            rx_ready,
  output logic [NUM_CH-1:0]            perr,
  output logic [NUM_CH-1:0]            ferr,
  output logic [NUM_CH-1:0]            ovf
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    ps2_rx_chan #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .ps2_clk (ps2_clk[c]),
      .ps2_data(ps2_data[c]),
      .rx_data (rx_data[PS2_BYTE_W*c +: PS2_BYTE_W]),
      .rx_valid(rx_valid[c]),
      .rx_ready(rx_ready[c]),
      .perr    (perr[c]),
      .ferr    (ferr[c]),
      .ovf     (ovf[c])
    );
  end

endmodule
